// File: rtl/vta_mem_arb_model.sv
// vta_mem_arb_model: behavioural memory shared by NUM_CH requester channels.
// One read or write burst runs at a time; channels are granted round-robin.
//
// Ports:
//   clock, reset                   clock and synchronous active-high reset
//   ch_req_valid/ready/opcode      per-channel burst request (opcode 1 = write)
//   ch_req_len, ch_req_addr        packed per channel: beats-1, byte address
//   ch_wr_valid/ready/bits         per-channel write beat stream
//   ch_rd_valid/ready              per-channel read beat handshake
//   ch_rd_bits                     shared read data bus, qualified by ch_rd_valid
//   busy                           a burst is in progress
module vta_mem_arb_model #(
    parameter int NUM_CH     = 2,
    parameter int LEN_BITS   = 8,
    parameter int ADDR_BITS  = 64,
    parameter int DATA_BITS  = 64,
    parameter int DEPTH_LOG2 = 12
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_CH-1:0]             ch_req_valid,
    output logic [NUM_CH-1:0]             ch_req_ready,
    input  logic [NUM_CH-1:0]             ch_req_opcode,
    input  logic [NUM_CH*LEN_BITS-1:0]    ch_req_len,
    input  logic [NUM_CH*ADDR_BITS-1:0]   ch_req_addr,
    input  logic [NUM_CH-1:0]             ch_wr_valid,
    output logic [NUM_CH-1:0]             ch_wr_ready,
    input  logic [NUM_CH*DATA_BITS-1:0]   ch_wr_bits,
    output logic [NUM_CH-1:0]             ch_rd_valid,
    output logic [DATA_BITS-1:0]          ch_rd_bits,
    input  logic [NUM_CH-1:0]             ch_rd_ready,
    output logic                          busy
);
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int BYTE_SH = $clog2(DATA_BITS / 8);
    localparam int DEPTH   = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_t;

    state_t                  r_state, w_next;
    logic [CH_W-1:0]         r_last, r_ch, w_gnt;
    logic                    w_gnt_vld, w_accept, w_wr_fire, w_rd_fire;
    logic [DEPTH_LOG2-1:0]   r_ptr, w_ptr_inc, w_word;
    logic [LEN_BITS-1:0]     r_rem, w_sel_len;
    logic                    w_sel_op;
    logic [ADDR_BITS-1:0]    w_sel_addr, w_addr_words_unused;
    logic                    r_rd_valid;
    logic [DATA_BITS-1:0]    r_rd_bits;
    logic [DATA_BITS-1:0]    r_mem [DEPTH];

    // Round-robin: scan from the farthest candidate down to last_grant+1 so
    // the nearest asserted channel after last_grant is the final assignment.
    always_comb begin : rr
        int idx;
        idx       = 0;
        w_gnt     = '0;
        w_gnt_vld = 1'b0;
        for (int k = NUM_CH; k >= 1; k--) begin
            idx = int'(r_last) + k;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (ch_req_valid[CH_W'(idx)]) begin
                w_gnt     = CH_W'(idx);
                w_gnt_vld = 1'b1;
            end
        end
    end

    assign w_sel_op            = ch_req_opcode[w_gnt];
    assign w_sel_len           = ch_req_len[w_gnt*LEN_BITS +: LEN_BITS];
    assign w_sel_addr          = ch_req_addr[w_gnt*ADDR_BITS +: ADDR_BITS];
    assign w_addr_words_unused = w_sel_addr >> BYTE_SH;
    // Word index modulo depth: low byte-lane bits and high bits are dropped.
    assign w_word              = w_addr_words_unused[DEPTH_LOG2-1:0];
    assign w_ptr_inc           = r_ptr + DEPTH_LOG2'(1);
    assign ch_rd_bits          = r_rd_bits;

    always_ff @(posedge clock) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        ch_req_ready = '0;
        ch_wr_ready  = '0;
        ch_rd_valid  = '0;
        busy         = 1'b0;
        w_accept     = 1'b0;
        w_wr_fire    = 1'b0;
        w_rd_fire    = 1'b0;
        case (r_state)
            S_IDLE: if (w_gnt_vld) begin
                ch_req_ready[w_gnt] = 1'b1;
                w_accept            = 1'b1;
                w_next              = w_sel_op ? S_WR : S_RD;
            end
            S_WR: begin
                busy              = 1'b1;
                ch_wr_ready[r_ch] = 1'b1;
                w_wr_fire         = ch_wr_valid[r_ch];
                if (w_wr_fire && r_rem == '0) w_next = S_IDLE;
            end
            S_RD: begin
                busy              = 1'b1;
                ch_rd_valid[r_ch] = r_rd_valid;
                w_rd_fire         = r_rd_valid & ch_rd_ready[r_ch];
                if (w_rd_fire && r_rem == '0) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        // Reset is synchronous, so the state register still holds its old
        // value during the reset cycle; mask every handshake combinationally.
        if (reset) begin
            ch_req_ready = '0;
            ch_wr_ready  = '0;
            ch_rd_valid  = '0;
            busy         = 1'b0;
            w_accept     = 1'b0;
            w_wr_fire    = 1'b0;
            w_rd_fire    = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_last     <= CH_W'(NUM_CH - 1);
            r_ch       <= '0;
            r_ptr      <= '0;
            r_rem      <= '0;
            r_rd_valid <= 1'b0;
            r_rd_bits  <= '0;
        end else begin
            if (w_accept) begin
                r_last <= w_gnt;
                r_ch   <= w_gnt;
                r_rem  <= w_sel_len;
                r_ptr  <= w_word;
                if (!w_sel_op) begin
                    // First read beat is registered straight from the array.
                    r_rd_valid <= 1'b1;
                    r_rd_bits  <= r_mem[w_word];
                end
            end
            if (w_wr_fire) begin
                r_ptr <= w_ptr_inc;
                r_rem <= r_rem - LEN_BITS'(1);
            end
            if (w_rd_fire) begin
                if (r_rem == '0) begin
                    r_rd_valid <= 1'b0;
                end else begin
                    r_rd_bits <= r_mem[w_ptr_inc];
                    r_ptr     <= w_ptr_inc;
                    r_rem     <= r_rem - LEN_BITS'(1);
                end
            end
        end
    end

    // Memory is never cleared by reset.
    always_ff @(posedge clock) begin
        if (w_wr_fire) r_mem[r_ptr] <= ch_wr_bits[r_ch*DATA_BITS +: DATA_BITS];
    end

endmodule

// File: tb/tb_vta_mem_arb_model.sv
// Directed bench for vta_mem_arb_model (2 channels, 16-word memory).
// Expected read beats are queued when a read is issued and compared by a
// negedge monitor at each rd handshake.
module tb_vta_mem_arb_model;
    localparam int NC = 2, LB = 8, AB = 64, DB = 64, DL = 4;

    logic              clock = 1'b0;
    logic              reset;
    logic [NC-1:0]     ch_req_valid, ch_req_ready, ch_req_opcode;
    logic [NC*LB-1:0]  ch_req_len;
    logic [NC*AB-1:0]  ch_req_addr;
    logic [NC-1:0]     ch_wr_valid, ch_wr_ready;
    logic [NC*DB-1:0]  ch_wr_bits;
    logic [NC-1:0]     ch_rd_valid, ch_rd_ready;
    logic [DB-1:0]     ch_rd_bits;
    logic              busy;

    vta_mem_arb_model #(.NUM_CH(NC), .LEN_BITS(LB), .ADDR_BITS(AB),
                        .DATA_BITS(DB), .DEPTH_LOG2(DL)) dut (
        .clock(clock), .reset(reset),
        .ch_req_valid(ch_req_valid), .ch_req_ready(ch_req_ready),
        .ch_req_opcode(ch_req_opcode), .ch_req_len(ch_req_len),
        .ch_req_addr(ch_req_addr),
        .ch_wr_valid(ch_wr_valid), .ch_wr_ready(ch_wr_ready),
        .ch_wr_bits(ch_wr_bits),
        .ch_rd_valid(ch_rd_valid), .ch_rd_bits(ch_rd_bits),
        .ch_rd_ready(ch_rd_ready), .busy(busy)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;
    logic [DB-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock); #1;
    endtask

    // Read beat scoreboard.
    always @(negedge clock) begin
        for (int c = 0; c < NC; c++) begin
            if (ch_rd_valid[c] && ch_rd_ready[c]) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $error("FAIL rd_extra: observed beat %0h on ch%0d, expected none", ch_rd_bits, c);
                end else begin
                    chk("rd_data", ch_rd_bits, exp_q.pop_front());
                end
            end
        end
    end

    // Issue a request and return one tick after the accepting edge.
    task automatic req(input int ch, input logic op, input int len, input logic [63:0] addr);
        logic got;
        got = 1'b0;
        ch_req_valid[ch]           = 1'b1;
        ch_req_opcode[ch]          = op;
        ch_req_len[ch*LB +: LB]    = LB'(len);
        ch_req_addr[ch*AB +: AB]   = addr;
        for (int t = 0; t < 50; t++) begin
            @(negedge clock);
            if (ch_req_ready[ch]) begin got = 1'b1; break; end
        end
        n_tests++;
        assert (got) else begin
            n_fail++;
            $error("FAIL req_timeout: observed no ready on ch%0d, expected ready", ch);
        end
        step();
        ch_req_valid[ch] = 1'b0;
    endtask

    task automatic wr_beats(input int ch, input int n, input logic [63:0] base);
        for (int i = 0; i < n; i++) begin
            ch_wr_valid[ch]          = 1'b1;
            ch_wr_bits[ch*DB +: DB]  = base + 64'(i);
            @(negedge clock);
            chk("wr_ready", {62'd0, ch_wr_ready}, 64'(1 << ch));
            step();
        end
        ch_wr_valid[ch] = 1'b0;
    endtask

    task automatic wait_rd_done();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 100) begin step(); t++; end
        n_tests++;
        assert (exp_q.size() == 0) else begin
            n_fail++;
            $error("FAIL rd_timeout: observed %0d beats pending, expected 0", exp_q.size());
        end
    endtask

    task automatic do_read(input int ch, input int len, input logic [63:0] addr);
        ch_rd_ready[ch] = 1'b1;
        req(ch, 1'b0, len, addr);
        @(negedge clock);
        chk("rd_first_latency", {62'd0, ch_rd_valid}, 64'(1 << ch));
        wait_rd_done();
        ch_rd_ready = '0;
        @(negedge clock);
        chk("rd_end_valid", {62'd0, ch_rd_valid}, 64'd0);
        chk("rd_end_busy", {63'd0, busy}, 64'd0);
        step();
    endtask

    initial begin
        logic [NC-1:0] exp_g;
        int g;
        reset = 1'b1;
        ch_req_valid = '1; ch_req_opcode = '0; ch_req_len = '0; ch_req_addr = '0;
        ch_wr_valid = '1; ch_wr_bits = '0; ch_rd_ready = '1;
        step(); step();
        @(negedge clock);
        chk("rst_req_ready", {62'd0, ch_req_ready}, 64'd0);
        chk("rst_wr_ready", {62'd0, ch_wr_ready}, 64'd0);
        chk("rst_rd_valid", {62'd0, ch_rd_valid}, 64'd0);
        chk("rst_rd_bits", ch_rd_bits, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        step();
        reset = 1'b0;
        ch_rd_ready = '0;

        // Both channels request len=0 writes continuously: 0,1,0,1.
        ch_req_valid = 2'b11; ch_req_opcode = 2'b11;
        ch_req_addr = {64'h08, 64'h00};
        ch_wr_bits = {64'hB0, 64'hA0};
        g = 0; exp_g = 2'b01;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            if (ch_req_ready != '0) begin
                chk("rr_grant", {62'd0, ch_req_ready}, {62'd0, exp_g});
                g++;
            end else begin
                chk("rr_wr_ready", {62'd0, ch_wr_ready}, {62'd0, exp_g});
                exp_g = ~exp_g;
            end
            step();
        end
        ch_req_valid = '0; ch_wr_valid = '0;
        chk("rr_count", 64'(g), 64'd4);
        step();
        exp_q.push_back(64'hA0); exp_q.push_back(64'hB0);
        do_read(0, 1, 64'h00);

        // Write 1..4 at 0x40 then read back.
        req(0, 1'b1, 3, 64'h40);
        wr_beats(0, 4, 64'd1);
        @(negedge clock);
        chk("wr_end_busy", {63'd0, busy}, 64'd0);
        step();
        for (int i = 1; i <= 4; i++) exp_q.push_back(64'(i));
        do_read(0, 3, 64'h40);

        // Read len=2 with a 3-cycle stall on beat 2; ch1 rd_ready is ignored.
        for (int i = 1; i <= 3; i++) exp_q.push_back(64'(i));
        ch_rd_ready[0] = 1'b1;
        req(0, 1'b0, 2, 64'h40);
        @(negedge clock);
        step();
        ch_rd_ready = 2'b10;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("stall_valid", {62'd0, ch_rd_valid}, 64'd1);
            chk("stall_bits", ch_rd_bits, 64'd2);
            step();
        end
        ch_rd_ready = 2'b01;
        wait_rd_done();
        ch_rd_ready = '0;
        @(negedge clock);
        chk("stall_end_valid", {62'd0, ch_rd_valid}, 64'd0);
        step();

        // Burst end while ch1 holds req_valid: no same-cycle acceptance.
        req(0, 1'b1, 1, 64'h10);
        ch_req_valid[1] = 1'b1; ch_req_opcode[1] = 1'b0;
        ch_req_len[LB +: LB] = 8'd1; ch_req_addr[AB +: AB] = 64'h10;
        ch_wr_valid[0] = 1'b1; ch_wr_bits[0 +: DB] = 64'h11;
        @(negedge clock);
        chk("b2b_mid_req_ready", {62'd0, ch_req_ready}, 64'd0);
        step();
        ch_wr_bits[0 +: DB] = 64'h22;
        @(negedge clock);
        chk("b2b_last_req_ready", {62'd0, ch_req_ready}, 64'd0);
        step();
        ch_wr_valid = '0; ch_rd_ready[1] = 1'b1;
        exp_q.push_back(64'h11); exp_q.push_back(64'h22);
        @(negedge clock);
        chk("b2b_next_req_ready", {62'd0, ch_req_ready}, 64'd2);
        step();
        ch_req_valid = '0;
        wait_rd_done();
        ch_rd_ready = '0;
        step();

        // Wrap: word 15 then word 0.
        req(1, 1'b1, 1, 64'h78);
        wr_beats(1, 2, 64'hA);
        exp_q.push_back(64'hA); exp_q.push_back(64'hB);
        do_read(0, 1, 64'h78);
        exp_q.push_back(64'hB);
        do_read(1, 0, 64'h00);

        // Reset after 2 of 4 write beats.
        req(0, 1'b1, 3, 64'h20);
        wr_beats(0, 2, 64'h51);
        reset = 1'b1;
        @(negedge clock);
        chk("rst_mid_busy", {63'd0, busy}, 64'd0);
        chk("rst_mid_wr_ready", {62'd0, ch_wr_ready}, 64'd0);
        step();
        reset = 1'b0;
        @(negedge clock);
        chk("post_rst_busy", {63'd0, busy}, 64'd0);
        step();
        exp_q.push_back(64'h51); exp_q.push_back(64'h52);
        do_read(0, 1, 64'h20);

        step(); step();
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
